// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : In-order fetch queue between pre-IF and ID. It matches SRAM
//            responses to their PCs and drops responses cancelled by a flush.
// Revision : 1.0
// ============================================================================
module if_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pfs_valid,
  input  logic [PC_W-1:0]   pfs_pc,
  output logic              pfs_ready,
  output logic              inst_sram_req,
  output logic [PC_W-1:0]   inst_sram_addr,
  input  logic              inst_sram_addr_ok,
  input  logic              inst_sram_data_ok,
  input  logic [INST_W-1:0] inst_sram_rdata,
  input  logic              flush,
  input  logic              ds_allowin,
  output logic              fs_to_ds_valid,
  output logic [PC_W-1:0]   fs_pc,
  output logic [INST_W-1:0] fs_inst,
  output logic              fs_adef,
  output logic              fs_empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_PW = c_AW + 1;
  localparam logic [c_PW-1:0] c_DEPTH = c_PW'(DEPTH);
  localparam logic [c_PW-1:0] c_ONE   = c_PW'(1);

  logic [PC_W-1:0]   r_pc   [DEPTH];
  logic [INST_W-1:0] r_inst [DEPTH];
  logic              r_adef [DEPTH];

  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_dt_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] r_discard_cnt;

  logic [c_PW-1:0] w_pending;
  logic [c_PW-1:0] w_occupied;
  logic [c_PW-1:0] w_reserved;
  logic            w_full;
  logic            w_data_wr;
  logic            w_pop;
  logic [c_AW-1:0] w_wr_idx;
  logic [c_AW-1:0] w_dt_idx;
  logic [c_AW-1:0] w_rd_idx;

  assign w_pending  = r_wr_ptr - r_dt_ptr;
  assign w_occupied = r_wr_ptr - r_rd_ptr;
  // Responses still to be dropped hold queue slots so the total never exceeds DEPTH.
  assign w_reserved = w_occupied + r_discard_cnt;
  assign w_full     = (w_reserved == c_DEPTH);

  assign w_wr_idx = r_wr_ptr[c_AW-1:0];
  assign w_dt_idx = r_dt_ptr[c_AW-1:0];
  assign w_rd_idx = r_rd_ptr[c_AW-1:0];

  assign inst_sram_req  = pfs_valid & ~w_full & ~flush & ~reset;
  assign inst_sram_addr = pfs_pc;
  assign pfs_ready      = inst_sram_req & inst_sram_addr_ok;

  assign w_data_wr = inst_sram_data_ok & ~flush & ~reset
                   & (r_discard_cnt == '0) & (w_pending != '0);

  assign fs_to_ds_valid = (r_dt_ptr != r_rd_ptr) & ~flush & ~reset;
  assign w_pop          = fs_to_ds_valid & ds_allowin;
  assign fs_pc          = r_pc[w_rd_idx];
  assign fs_inst        = r_inst[w_rd_idx];
  assign fs_adef        = r_adef[w_rd_idx];
  assign fs_empty       = (r_wr_ptr == r_rd_ptr) | reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_dt_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_discard_cnt <= '0;
    end else if (flush) begin
      // Every outstanding response, including one arriving now, becomes a discard.
      r_rd_ptr      <= r_wr_ptr;
      r_dt_ptr      <= r_wr_ptr;
      r_discard_cnt <= r_discard_cnt + w_pending - c_PW'(inst_sram_data_ok);
    end else begin
      if (pfs_ready) begin
        r_wr_ptr <= r_wr_ptr + c_ONE;
      end
      if (inst_sram_data_ok && (r_discard_cnt != '0)) begin
        r_discard_cnt <= r_discard_cnt - c_ONE;
      end
      if (w_data_wr) begin
        r_dt_ptr <= r_dt_ptr + c_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pfs_ready) begin
      r_pc[w_wr_idx]   <= pfs_pc;
      r_adef[w_wr_idx] <= |pfs_pc[1:0];
    end
    if (w_data_wr) begin
      r_inst[w_dt_idx] <= inst_sram_rdata;
    end
  end

  a_no_orphan_data : assert property (@(posedge clk) disable iff (reset)
    inst_sram_data_ok |-> ((w_pending != '0) || (r_discard_cnt != '0)));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Purpose  : Directed vector table plus hand-written flush/reset sequences.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        pfs_valid;
  logic [31:0] pfs_pc;
  logic        pfs_ready;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        flush;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;
  logic        fs_empty;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .pfs_valid        (pfs_valid),
    .pfs_pc           (pfs_pc),
    .pfs_ready        (pfs_ready),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata),
    .flush            (flush),
    .ds_allowin       (ds_allowin),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_pc            (fs_pc),
    .fs_inst          (fs_inst),
    .fs_adef          (fs_adef),
    .fs_empty         (fs_empty)
  );

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        allow;
    logic        e_req;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_adef;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pv, logic [31:0] pc, logic aok, logic dok,
                              logic [31:0] rdata, logic allow, logic e_req,
                              logic e_ready, logic e_valid, logic [31:0] e_pc,
                              logic [31:0] e_inst, logic e_adef, logic e_empty);
    vec_t v;
    v.pv = pv; v.pc = pc; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.allow = allow; v.e_req = e_req; v.e_ready = e_ready; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_adef = e_adef; v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs just after the rising edge and returns at the falling edge.
  task automatic drive(input logic pv, input logic [31:0] pc, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic fl,
                       input logic allow);
    @(posedge clk);
    #1;
    pfs_valid         = pv;
    pfs_pc            = pc;
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dok;
    inst_sram_rdata   = rd;
    flush             = fl;
    ds_allowin        = allow;
    @(negedge clk);
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc, input logic [31:0] inst,
                          input logic adef);
    chk({name, " valid"}, fs_to_ds_valid, 1'b1);
    chk({name, " pc"}, fs_pc, pc);
    chk({name, " inst"}, fs_inst, inst);
    chk({name, " adef"}, fs_adef, adef);
  endtask

  localparam logic [31:0] A = 32'h1c00_0000;
  localparam logic [31:0] B = 32'h1c00_0010;

  initial begin
    // Throughput: one instruction per cycle in PC order.
    vecs.push_back(mk(1, A,     1, 0, 0,            1, 1, 1, 0, 0,     0,            0, 1));
    vecs.push_back(mk(1, A+4,   1, 1, 32'ha0000000, 1, 1, 1, 0, 0,     0,            0, 0));
    vecs.push_back(mk(1, A+8,   1, 1, 32'ha0000001, 1, 1, 1, 1, A,     32'ha0000000, 0, 0));
    vecs.push_back(mk(1, A+12,  1, 1, 32'ha0000002, 1, 1, 1, 1, A+4,   32'ha0000001, 0, 0));
    vecs.push_back(mk(0, 0,     1, 1, 32'ha0000003, 1, 0, 0, 1, A+8,   32'ha0000002, 0, 0));
    vecs.push_back(mk(0, 0,     1, 0, 0,            1, 0, 0, 1, A+12,  32'ha0000003, 0, 0));
    vecs.push_back(mk(0, 0,     1, 0, 0,            1, 0, 0, 0, 0,     0,            0, 1));
    // Full stall with ID blocked, then drain in order and resume requests.
    vecs.push_back(mk(1, B,     1, 0, 0,            0, 1, 1, 0, 0,     0,            0, 1));
    vecs.push_back(mk(1, B+4,   1, 1, 32'hb0000000, 0, 1, 1, 0, 0,     0,            0, 0));
    vecs.push_back(mk(1, B+8,   1, 1, 32'hb0000001, 0, 1, 1, 1, B,     32'hb0000000, 0, 0));
    vecs.push_back(mk(1, B+12,  1, 1, 32'hb0000002, 0, 1, 1, 1, B,     32'hb0000000, 0, 0));
    vecs.push_back(mk(1, B+16,  1, 1, 32'hb0000003, 0, 0, 0, 1, B,     32'hb0000000, 0, 0));
    vecs.push_back(mk(1, B+16,  1, 0, 0,            0, 0, 0, 1, B,     32'hb0000000, 0, 0));
    vecs.push_back(mk(1, B+16,  1, 0, 0,            1, 0, 0, 1, B,     32'hb0000000, 0, 0));
    vecs.push_back(mk(1, B+16,  1, 0, 0,            1, 1, 1, 1, B+4,   32'hb0000001, 0, 0));
    vecs.push_back(mk(0, 0,     1, 1, 32'hb0000004, 1, 0, 0, 1, B+8,   32'hb0000002, 0, 0));
    vecs.push_back(mk(0, 0,     1, 0, 0,            1, 0, 0, 1, B+12,  32'hb0000003, 0, 0));
    vecs.push_back(mk(0, 0,     1, 0, 0,            1, 0, 0, 1, B+16,  32'hb0000004, 0, 0));
    vecs.push_back(mk(0, 0,     1, 0, 0,            1, 0, 0, 0, 0,     0,            0, 1));
    // Misaligned PC is still fetched and flagged.
    vecs.push_back(mk(1, 32'h1c000002, 1, 0, 0,     1, 1, 1, 0, 0,     0,            0, 1));
    vecs.push_back(mk(0, 0,     1, 1, 32'hc0000000, 1, 0, 0, 0, 0,     0,            0, 0));
    vecs.push_back(mk(0, 0,     1, 0, 0,            1, 0, 0, 1, 32'h1c000002, 32'hc0000000, 1, 0));
    // Request without addr_ok: no handshake, nothing queued.
    vecs.push_back(mk(1, 32'h1c000030, 0, 0, 0,     1, 1, 0, 0, 0,     0,            0, 1));
    vecs.push_back(mk(0, 0,     1, 0, 0,            1, 0, 0, 0, 0,     0,            0, 1));

    pfs_valid = 1'b1; pfs_pc = A; inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b0;
    inst_sram_rdata = '0; flush = 1'b0; ds_allowin = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset req", inst_sram_req, 1'b0);
    chk("reset ready", pfs_ready, 1'b0);
    chk("reset valid", fs_to_ds_valid, 1'b0);
    chk("reset empty", fs_empty, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pfs_valid = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].pc, vecs[i].aok, vecs[i].dok, vecs[i].rdata, 1'b0, vecs[i].allow);
      chk($sformatf("v%0d req", i), inst_sram_req, vecs[i].e_req);
      chk($sformatf("v%0d ready", i), pfs_ready, vecs[i].e_ready);
      chk($sformatf("v%0d valid", i), fs_to_ds_valid, vecs[i].e_valid);
      chk($sformatf("v%0d empty", i), fs_empty, vecs[i].e_empty);
      if (vecs[i].pv) chk($sformatf("v%0d addr", i), inst_sram_addr, vecs[i].pc);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d pc", i), fs_pc, vecs[i].e_pc);
        chk($sformatf("v%0d inst", i), fs_inst, vecs[i].e_inst);
        chk($sformatf("v%0d adef", i), fs_adef, vecs[i].e_adef);
      end
    end

    // Flush with three responses pending.
    drive(1, 32'h1c000040, 1, 0, 0, 0, 1);
    drive(1, 32'h1c000044, 1, 0, 0, 0, 1);
    drive(1, 32'h1c000048, 1, 0, 0, 0, 1);
    drive(1, 32'h1c00004c, 1, 0, 0, 1, 1);
    chk("f3 flush req", inst_sram_req, 1'b0);
    chk("f3 flush valid", fs_to_ds_valid, 1'b0);
    drive(1, 32'h1c000100, 1, 0, 0, 0, 1);
    chk("f3 discard", dut.r_discard_cnt, 3);
    chk("f3 req after flush", pfs_ready, 1'b1);
    chk("f3 empty", fs_empty, 1'b1);
    drive(1, 32'h1c000104, 1, 1, 32'hdead0001, 0, 1);
    chk("f3 reserved full", inst_sram_req, 1'b0);
    chk("f3 drop1 valid", fs_to_ds_valid, 1'b0);
    drive(0, 0, 1, 1, 32'hdead0002, 0, 1);
    chk("f3 drop2 valid", fs_to_ds_valid, 1'b0);
    drive(0, 0, 1, 1, 32'hdead0003, 0, 1);
    chk("f3 drop3 valid", fs_to_ds_valid, 1'b0);
    drive(0, 0, 1, 1, 32'h1c0de100, 0, 1);
    chk("f3 discard drained", dut.r_discard_cnt, 0);
    chk("f3 no bypass", fs_to_ds_valid, 1'b0);
    drive(0, 0, 1, 0, 0, 0, 1);
    chk_head("f3 deliver", 32'h1c000100, 32'h1c0de100, 1'b0);
    drive(0, 0, 1, 0, 0, 0, 1);
    chk("f3 empty after", fs_empty, 1'b1);

    // Flush coincident with data_ok: discard 1 + pending 2 - 1.
    drive(1, 32'h1c000200, 1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 1, 1);
    drive(1, 32'h1c000204, 1, 0, 0, 0, 1);
    chk("f4 req1", pfs_ready, 1'b1);
    drive(1, 32'h1c000208, 1, 0, 0, 0, 1);
    chk("f4 req2", pfs_ready, 1'b1);
    drive(0, 0, 1, 1, 32'hbad00000, 1, 1);
    chk("f4 flush valid", fs_to_ds_valid, 1'b0);
    drive(1, 32'h1c000300, 1, 0, 0, 0, 1);
    chk("f4 discard", dut.r_discard_cnt, 2);
    chk("f4 req", pfs_ready, 1'b1);
    drive(0, 0, 1, 1, 32'hbad00001, 0, 1);
    drive(0, 0, 1, 1, 32'hbad00002, 0, 1);
    chk("f4 drop valid", fs_to_ds_valid, 1'b0);
    drive(0, 0, 1, 1, 32'h600d0300, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 1);
    chk_head("f4 deliver", 32'h1c000300, 32'h600d0300, 1'b0);

    // Reset with two buffered entries and one pending response.
    drive(1, 32'h1c000400, 1, 0, 0, 0, 0);
    drive(1, 32'h1c000404, 1, 1, 32'h44000400, 0, 0);
    drive(1, 32'h1c000408, 1, 1, 32'h44000404, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    chk_head("f6 before reset", 32'h1c000400, 32'h44000400, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    pfs_valid = 1'b1;
    pfs_pc = 32'h1c000500;
    @(negedge clk);
    chk("f6 reset req", inst_sram_req, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pfs_valid = 1'b0;
    @(negedge clk);
    chk("f6 valid", fs_to_ds_valid, 1'b0);
    chk("f6 empty", fs_empty, 1'b1);
    chk("f6 discard", dut.r_discard_cnt, 0);
    drive(1, 32'h1c000500, 1, 0, 0, 0, 1);
    chk("f6 req", pfs_ready, 1'b1);
    drive(0, 0, 1, 1, 32'h55000500, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 1);
    chk_head("f6 deliver", 32'h1c000500, 32'h55000500, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
